// File: rtl/ldpc_decode_sched_if.sv
// Scheduler <-> decoder core link: layer command handshake and hard-decision read port.
// master = scheduler side, slave = check-node core / hard-decision memory side.
interface ldpc_decode_sched_if #(
   parameter int WIDTH    = 16,
   parameter int N_WORDS  = 64,
   parameter int N_LAYERS = 4
);
   logic                        o_layer_start;
   logic [$clog2(N_LAYERS)-1:0] o_layer_idx;
   logic                        i_layer_done;
   logic                        i_parity_ok;
   logic                        o_rd_en;
   logic [$clog2(N_WORDS)-1:0]  o_rd_addr;
   logic [WIDTH-1:0]            i_rd_data;

   modport master (
      output o_layer_start, o_layer_idx, o_rd_en, o_rd_addr,
      input  i_layer_done, i_parity_ok, i_rd_data
   );

   modport slave (
      input  o_layer_start, o_layer_idx, o_rd_en, o_rd_addr,
      output i_layer_done, i_parity_ok, i_rd_data
   );
endinterface

// File: rtl/ldpc_decode_sched.sv
// Frame-level LDPC decode scheduler: load LLRs, sequence layers/iterations, unload hard decisions.
// Define LDPC_EARLY_TERM_EN to stop iterating as soon as one whole iteration passes parity.
module ldpc_decode_sched #(
   parameter int WIDTH    = 16,
   parameter int N_WORDS  = 64,
   parameter int N_LAYERS = 4,
   parameter int MAX_ITER = 8
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic [WIDTH-1:0]              i_in_data,
   input  logic                          i_in_valid,
   output logic                          o_llr_wr_en,
   output logic [$clog2(N_WORDS)-1:0]    o_llr_wr_addr,
   output logic [WIDTH-1:0]              o_llr_wr_data,
   ldpc_decode_sched_if.master           core,
   output logic [WIDTH-1:0]              o_out_data,
   output logic                          o_out_valid,
   output logic                          o_frame_done,
   output logic [$clog2(MAX_ITER+1)-1:0] o_iter_count,
   output logic                          o_converged,
   output logic                          o_overflow,
   output logic                          o_busy
);
   localparam int AW = $clog2(N_WORDS);
   localparam int LW = $clog2(N_LAYERS);
   localparam int IW = $clog2(MAX_ITER+1);

   localparam logic [AW-1:0] ADDR_ONE   = AW'(1);
   localparam logic [AW-1:0] ADDR_LAST  = AW'(N_WORDS-1);
   localparam logic [LW-1:0] LAYER_ONE  = LW'(1);
   localparam logic [LW-1:0] LAYER_LAST = LW'(N_LAYERS-1);
   localparam logic [IW-1:0] ITER_ONE   = IW'(1);
   localparam logic [IW-1:0] ITER_LAST  = IW'(MAX_ITER-1);
   localparam logic [AW:0]   RD_ONE     = (AW+1)'(1);
   localparam logic [AW:0]   RD_LAST    = (AW+1)'(N_WORDS-1);
   localparam logic [AW:0]   RD_END     = (AW+1)'(N_WORDS);

   typedef enum logic [2:0] {IDLE, LOAD, LSTART, LWAIT, UNLOAD} state_t;

   state_t          r_state;
   state_t          w_nextState;
   logic [AW-1:0]   r_loadAddr;
   logic [LW-1:0]   r_layer;
   logic            r_allOk;
   logic [IW-1:0]   r_iterCount;
   logic            r_converged;
   logic            r_overflow;
   logic [AW:0]     r_rdCnt;
   logic            r_outValid;
   logic            r_frameDone;
   logic            r_wrEn;
   logic [AW-1:0]   r_wrAddr;
   logic [WIDTH-1:0] r_wrData;

   logic w_accept;
   logic w_layerLast;
   logic w_okSoFar;
   logic w_layerDone;
   logic w_iterEnd;
   logic w_stop;
   logic w_rdActive;

   // Input words are only taken while idle or loading; anything else is a drop.
   always_comb begin
      w_accept    = i_in_valid && (r_state == IDLE || r_state == LOAD);
      w_layerLast = (r_layer == LAYER_LAST);
      w_okSoFar   = r_allOk & core.i_parity_ok;
      w_layerDone = (r_state == LWAIT) && core.i_layer_done;
      w_iterEnd   = w_layerDone && w_layerLast;
      w_rdActive  = (r_state == UNLOAD) && (r_rdCnt != RD_END);
`ifdef LDPC_EARLY_TERM_EN
      w_stop      = w_okSoFar || (r_iterCount == ITER_LAST);
`else
      w_stop      = (r_iterCount == ITER_LAST);
`endif
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_nextState;
   end

   // UNLOAD lingers one cycle past the last read so frame_done can drain before IDLE.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (i_in_valid) w_nextState = LOAD;
         LOAD:    if (i_in_valid && r_loadAddr == ADDR_LAST) w_nextState = LSTART;
         LSTART:  w_nextState = LWAIT;
         LWAIT: begin
            if (w_layerDone) begin
               if (!w_layerLast)  w_nextState = LSTART;
               else if (w_stop)   w_nextState = UNLOAD;
               else               w_nextState = LSTART;
            end
         end
         UNLOAD:  if (r_rdCnt == RD_END) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Datapath counters and registered outputs, all stepped by the current state.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_loadAddr  <= '0;
         r_layer     <= '0;
         r_allOk     <= 1'b0;
         r_iterCount <= '0;
         r_converged <= 1'b0;
         r_overflow  <= 1'b0;
         r_rdCnt     <= '0;
         r_outValid  <= 1'b0;
         r_frameDone <= 1'b0;
         r_wrEn      <= 1'b0;
         r_wrAddr    <= '0;
         r_wrData    <= '0;
      end else begin
         r_wrEn <= w_accept;
         if (w_accept) r_wrData <= i_in_data;
         if (i_in_valid && !w_accept) r_overflow <= 1'b1;

         if (r_state == IDLE && i_in_valid) begin
            r_wrAddr    <= '0;
            r_loadAddr  <= ADDR_ONE;
            r_iterCount <= '0;
            r_converged <= 1'b0;
         end

         if (r_state == LOAD && i_in_valid) begin
            r_wrAddr <= r_loadAddr;
            if (r_loadAddr == ADDR_LAST) begin
               r_layer <= '0;
               r_allOk <= 1'b1;
            end else begin
               r_loadAddr <= r_loadAddr + ADDR_ONE;
            end
         end

         if (w_layerDone) begin
            if (!w_layerLast) begin
               r_layer <= r_layer + LAYER_ONE;
               r_allOk <= w_okSoFar;
            end else begin
               r_layer <= '0;
               r_allOk <= 1'b1;
            end
         end

         if (w_iterEnd) begin
            r_iterCount <= r_iterCount + ITER_ONE;
            r_converged <= w_okSoFar;
         end

         if (r_state != UNLOAD) r_rdCnt <= '0;
         else if (w_rdActive)   r_rdCnt <= r_rdCnt + RD_ONE;

         r_outValid  <= w_rdActive;
         r_frameDone <= w_rdActive && (r_rdCnt == RD_LAST);
      end
   end

   assign o_llr_wr_en        = r_wrEn;
   assign o_llr_wr_addr      = r_wrAddr;
   assign o_llr_wr_data      = r_wrData;
   assign core.o_layer_start = (r_state == LSTART);
   assign core.o_layer_idx   = r_layer;
   assign core.o_rd_en       = w_rdActive;
   assign core.o_rd_addr     = r_rdCnt[AW-1:0];
   assign o_out_data         = core.i_rd_data;
   assign o_out_valid        = r_outValid;
   assign o_frame_done       = r_frameDone;
   assign o_iter_count       = r_iterCount;
   assign o_converged        = r_converged;
   assign o_overflow         = r_overflow;
   assign o_busy             = (r_state != IDLE);
endmodule
